// File: rtl/weight_stream_ctrl_if.sv
// Handshake, memory and kernel bus of the weight stream loader.
// slave = loader side, master = controller/memory side.
interface weight_stream_ctrl_if #(
  parameter int KERNEL_WIDTH = 72,
  parameter int NUM_MAC      = 4,
  parameter int TAPS         = 3,
  parameter int ADDR_WIDTH   = 10
);
  logic                                 i_start;
  logic [ADDR_WIDTH-1:0]                i_base_addr;
  logic [ADDR_WIDTH-1:0]                i_num_sets;
  logic                                 i_consume;
  logic                                 i_abort;
  logic                                 o_mem_en;
  logic [ADDR_WIDTH-1:0]                o_mem_addr;
  logic [NUM_MAC*KERNEL_WIDTH-1:0]      i_mem_data;
  logic [NUM_MAC*TAPS*KERNEL_WIDTH-1:0] o_kernel;
  logic                                 o_valid;
  logic                                 o_busy;
  logic                                 o_done;

  modport slave (
    input  i_start, i_base_addr, i_num_sets, i_consume, i_abort, i_mem_data,
    output o_mem_en, o_mem_addr, o_kernel, o_valid, o_busy, o_done
  );

  modport master (
    output i_start, i_base_addr, i_num_sets, i_consume, i_abort, i_mem_data,
    input  o_mem_en, o_mem_addr, o_kernel, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/weight_stream_ctrl.sv
// Double-buffered weight loader: fetches TAPS words per MAC per set from
// NUM_MAC memories into a shadow bank and hands complete sets to the MAC array.
module weight_stream_ctrl #(
  parameter int KERNEL_WIDTH = 72,
  parameter int NUM_MAC      = 4,
  parameter int TAPS         = 3,
  parameter int ADDR_WIDTH   = 10,
  parameter int RD_LAT       = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  weight_stream_ctrl_if.slave   bus
);
  localparam int KW     = KERNEL_WIDTH;
  localparam int BANK_W = NUM_MAC * TAPS * KW;
  localparam int CW     = $clog2(TAPS + 1);
  localparam logic [CW-1:0] TAPS_C  = CW'(TAPS);
  localparam logic [CW-1:0] TAPS_M1 = CW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  mem_en_q, mem_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         cap_cnt_q, cap_cnt_d;
  logic [RD_LAT-1:0]     pipe_q, pipe_d;
  logic [BANK_W-1:0]     shadow_q, shadow_d;
  logic [BANK_W-1:0]     active_q, active_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] num_sets_q, num_sets_d;
  logic [ADDR_WIDTH-1:0] sets_q, sets_d;
  logic [ADDR_WIDTH-1:0] sets_nxt;
  logic                  capture;

  assign capture  = pipe_q[RD_LAT-1];
  assign sets_nxt = sets_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    addr_d      = mem_en_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    num_sets_d  = num_sets_q;
    sets_d      = sets_q;
    pipe_d      = '0;
    pipe_d[0]   = mem_en_q;
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    // Returning words shift down so the first word of a set lands in tap 0.
    if (capture) begin
      for (int unsigned m = 0; m < NUM_MAC; m++) begin
        for (int unsigned t = 0; t + 1 < TAPS; t++)
          shadow_d[(m*TAPS+t)*KW +: KW] = shadow_q[(m*TAPS+t+1)*KW +: KW];
        shadow_d[(m*TAPS+TAPS-1)*KW +: KW] = bus.i_mem_data[m*KW +: KW];
      end
      cap_cnt_d = cap_cnt_q + CW'(1);
    end

    if (bus.i_consume && valid_q) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          num_sets_d = bus.i_num_sets;
          sets_d     = '0;
          if (bus.i_num_sets == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = FETCH;
            addr_d      = bus.i_base_addr;
            mem_en_d    = 1'b1;
            issue_cnt_d = CW'(1);
            cap_cnt_d   = '0;
          end
        end
      end
      FETCH: begin
        if (issue_cnt_q < TAPS_C) begin
          mem_en_d    = 1'b1;
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        if (capture && cap_cnt_q == TAPS_M1) begin
          state_d   = FULL;
          cap_cnt_d = '0;
        end
      end
      FULL: begin
        // A consume on the transfer edge swaps sets without dropping o_valid.
        if (!valid_q || bus.i_consume) begin
          active_d = shadow_q;
          valid_d  = 1'b1;
          sets_d   = sets_nxt;
          if (sets_nxt < num_sets_q) begin
            state_d     = FETCH;
            mem_en_d    = 1'b1;
            issue_cnt_d = CW'(1);
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (valid_q && bus.i_consume) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.i_abort) begin
      state_d     = IDLE;
      mem_en_d    = 1'b0;
      addr_d      = '0;
      issue_cnt_d = '0;
      cap_cnt_d   = '0;
      pipe_d      = '0;
      shadow_d    = '0;
      active_d    = '0;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      num_sets_d  = '0;
      sets_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      pipe_q      <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      num_sets_q  <= '0;
      sets_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pipe_q      <= pipe_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      num_sets_q  <= num_sets_d;
      sets_q      <= sets_d;
    end
  end

  assign bus.o_mem_en   = mem_en_q;
  assign bus.o_mem_addr = addr_q;
  assign bus.o_kernel   = active_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = done_q;
endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Bench for weight_stream_ctrl: table of start/count/hold runs plus directed
// sequences for latency, tied consume, seamless swap, abort and reset.
module tb_weight_stream_ctrl;
  localparam int KW     = 72;
  localparam int NM     = 4;
  localparam int TP     = 3;
  localparam int AW     = 10;
  localparam int BANK_W = NM * TP * KW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  weight_stream_ctrl_if #(.KERNEL_WIDTH(KW), .NUM_MAC(NM), .TAPS(TP), .ADDR_WIDTH(AW)) wif ();

  weight_stream_ctrl #(
    .KERNEL_WIDTH(KW), .NUM_MAC(NM), .TAPS(TP), .ADDR_WIDTH(AW), .RD_LAT(1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (wif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [AW-1:0] addr_log[$];

  function automatic logic [KW-1:0] mw(input int m, input logic [AW-1:0] a);
    logic [KW-1:0] w;
    w = '0;
    w[17:10] = 8'(m);
    w[9:0]   = a;
    return w;
  endfunction

  function automatic logic [BANK_W-1:0] exp_kernel(input logic [AW-1:0] base);
    logic [BANK_W-1:0] r;
    r = '0;
    for (int m = 0; m < NM; m++)
      for (int t = 0; t < TP; t++)
        r[(m*TP+t)*KW +: KW] = mw(m, base + AW'(t));
    return r;
  endfunction

  // Memory with one cycle of read latency; also logs every issued address.
  always @(posedge clk) begin
    if (wif.o_mem_en) begin
      addr_log.push_back(wif.o_mem_addr);
      for (int m = 0; m < NM; m++)
        wif.i_mem_data[m*KW +: KW] <= mw(m, wif.o_mem_addr);
    end
    if (wif.o_done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [BANK_W-1:0] act, input logic [BANK_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] n);
    @(negedge clk);
    wif.i_start     = 1'b1;
    wif.i_base_addr = base;
    wif.i_num_sets  = n;
    @(negedge clk);
    wif.i_start = 1'b0;
  endtask

  task automatic consume_pulse();
    wif.i_consume = 1'b1;
    @(negedge clk);
    wif.i_consume = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int k = 0;
    while (!wif.o_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    ok = wif.o_valid;
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] base;
    logic [AW-1:0] nsets;
    int            hold;
    int            exp_reads;
    logic [AW-1:0] exp_last;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit ok;
    bit seq_ok;
    int d0;
    addr_log.delete();
    d0 = done_cnt;
    start(v.base, v.nsets);
    if (v.nsets == '0) begin
      chk({v.name, "_done"}, wif.o_done, 1);
      chk({v.name, "_busy"}, wif.o_busy, 0);
      @(negedge clk);
      chk({v.name, "_done_low"}, wif.o_done, 0);
    end else begin
      for (int s = 0; s < int'(v.nsets); s++) begin
        wait_valid(ok);
        chk($sformatf("%s_valid%0d", v.name, s), ok, 1);
        chk($sformatf("%s_set%0d", v.name, s), wif.o_kernel, exp_kernel(v.base + AW'(3*s)));
        if (v.hold > 0) begin
          repeat (v.hold) @(negedge clk);
          chk($sformatf("%s_hold%0d", v.name, s), wif.o_kernel, exp_kernel(v.base + AW'(3*s)));
        end
        consume_pulse();
        if (s == int'(v.nsets) - 1) begin
          chk({v.name, "_done"}, wif.o_done, 1);
          chk({v.name, "_busy"}, wif.o_busy, 0);
          @(negedge clk);
          chk({v.name, "_done_low"}, wif.o_done, 0);
        end
      end
    end
    chk({v.name, "_reads"}, addr_log.size(), v.exp_reads);
    if (v.exp_reads > 0) begin
      chk({v.name, "_last_addr"}, addr_log[addr_log.size()-1], v.exp_last);
      seq_ok = 1'b1;
      foreach (addr_log[k]) if (addr_log[k] !== v.base + AW'(k)) seq_ok = 1'b0;
      chk({v.name, "_addr_seq"}, seq_ok, 1);
    end
    chk({v.name, "_done_cnt"}, done_cnt - d0, 1);
  endtask

  vec_t vecs[5];

  initial begin
    bit ok;
    int d0, k, seen;
    logic [BANK_W-1:0] last;

    vecs[0] = '{"one",   10'h010, 10'd1, 0, 3, 10'h012};
    vecs[1] = '{"wrap",  10'h3FE, 10'd2, 0, 6, 10'h003};
    vecs[2] = '{"hold3", 10'h200, 10'd3, 7, 9, 10'h208};
    vecs[3] = '{"zero",  10'h000, 10'd0, 0, 0, 10'h000};
    vecs[4] = '{"two",   10'h0F0, 10'd2, 1, 6, 10'h0F5};

    wif.i_start = 1'b0; wif.i_base_addr = '0; wif.i_num_sets = '0;
    wif.i_consume = 1'b0; wif.i_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", wif.o_valid, 0);
    chk("rst_busy", wif.o_busy, 0);
    chk("rst_done", wif.o_done, 0);
    chk("rst_en", wif.o_mem_en, 0);
    chk("rst_addr", wif.o_mem_addr, 0);
    chk("rst_kernel", wif.o_kernel, 0);
    rstn = 1'b1;

    // First-set latency, edge by edge
    addr_log.delete();
    start(10'h010, 10'd1);
    chk("lat_e0_en", wif.o_mem_en, 1);
    chk("lat_e0_addr", wif.o_mem_addr, 10'h010);
    chk("lat_e0_busy", wif.o_busy, 1);
    @(negedge clk); chk("lat_e1_addr", wif.o_mem_addr, 10'h011);
    @(negedge clk); chk("lat_e2_addr", wif.o_mem_addr, 10'h012);
    chk("lat_e2_en", wif.o_mem_en, 1);
    @(negedge clk); chk("lat_e3_en", wif.o_mem_en, 0);
    @(negedge clk); chk("lat_e4_valid", wif.o_valid, 0);
    @(negedge clk); chk("lat_e5_valid", wif.o_valid, 1);
    chk("lat_e5_kernel", wif.o_kernel, exp_kernel(10'h010));
    consume_pulse();
    chk("lat_done", wif.o_done, 1);
    chk("lat_valid_off", wif.o_valid, 0);
    chk("lat_kernel_held", wif.o_kernel, exp_kernel(10'h010));
    @(negedge clk); chk("lat_done_low", wif.o_done, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Consume tied high: every set seen, in order
    addr_log.delete();
    d0 = done_cnt; k = 0; seen = 0; last = '0;
    wif.i_consume = 1'b1;
    start(10'h010, 10'd4);
    while (done_cnt == d0 && k < 100) begin
      if (wif.o_valid && wif.o_kernel !== last) begin
        if (seen < 4)
          chk($sformatf("tied_set%0d", seen), wif.o_kernel, exp_kernel(10'h010 + AW'(3*seen)));
        seen++;
        last = wif.o_kernel;
      end
      @(negedge clk);
      k++;
    end
    wif.i_consume = 1'b0;
    chk("tied_sets", seen, 4);
    chk("tied_done_cnt", done_cnt - d0, 1);
    chk("tied_reads", addr_log.size(), 12);

    // Withheld consume then seamless swap
    addr_log.delete();
    start(10'h040, 10'd3);
    wait_valid(ok);
    chk("swap_valid", ok, 1);
    repeat (20) @(negedge clk);
    chk("swap_hold_en", wif.o_mem_en, 0);
    chk("swap_hold_reads", addr_log.size(), 6);
    chk("swap_hold_kernel", wif.o_kernel, exp_kernel(10'h040));
    consume_pulse();
    chk("swap_valid_kept", wif.o_valid, 1);
    chk("swap_set1", wif.o_kernel, exp_kernel(10'h043));
    consume_pulse();
    wait_valid(ok);
    chk("swap_set2", wif.o_kernel, exp_kernel(10'h046));
    consume_pulse();
    chk("swap_done", wif.o_done, 1);

    // Abort during second set's fetch, then a fresh run
    @(negedge clk);
    d0 = done_cnt;
    start(10'h080, 10'd3);
    wait_valid(ok);
    chk("abort_set0", wif.o_kernel, exp_kernel(10'h080));
    @(negedge clk);
    chk("abort_prefetch_en", wif.o_mem_en, 1);
    wif.i_abort = 1'b1;
    wif.i_consume = 1'b1;
    @(negedge clk);
    wif.i_abort = 1'b0;
    wif.i_consume = 1'b0;
    chk("abort_valid", wif.o_valid, 0);
    chk("abort_kernel", wif.o_kernel, 0);
    chk("abort_busy", wif.o_busy, 0);
    chk("abort_en", wif.o_mem_en, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    addr_log.delete();
    start(10'h100, 10'd1);
    wait_valid(ok);
    chk("post_abort_kernel", wif.o_kernel, exp_kernel(10'h100));
    consume_pulse();
    chk("post_abort_done", wif.o_done, 1);
    chk("post_abort_reads", addr_log.size(), 3);
    chk("post_abort_addr0", addr_log[0], 10'h100);

    // Asynchronous reset mid-fetch
    @(negedge clk);
    start(10'h020, 10'd2);
    wait_valid(ok);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", wif.o_valid, 0);
    chk("arst_busy", wif.o_busy, 0);
    chk("arst_en", wif.o_mem_en, 0);
    chk("arst_addr", wif.o_mem_addr, 0);
    chk("arst_kernel", wif.o_kernel, 0);
    chk("arst_done", wif.o_done, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_idle", wif.o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/weight_stream_ctrl.md
# weight_stream_ctrl

Parametrised weight loader for the MAC array: on a start command it fetches a programmable number of weight sets from NUM_MAC external read-only weight memories. Each set is TAPS consecutive words per MAC. The block presents one set at a time as a stable, registered kernel bus and prefetches the next set into a shadow bank. Successor to the fixed 4-MAC × 3-tap loader: width, MAC count, tap depth and memory read latency are generalised, and it adds start/consume/done handshakes, double-buffering and abort.

## Interface
- KERNEL_WIDTH, 72, bits per kernel word (9 × 8-bit weights)
- NUM_MAC, 4, MAC channels / weight memories read in parallel
- TAPS, 3, kernel words per MAC per set
- ADDR_WIDTH, 10, memory address width
- RD_LAT, 1, memory read latency in cycles (≥1)
- clk  in  1  clock; single clock domain
- rstn  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_base_addr  in  ADDR_WIDTH  first word address, latched on accepted start
- i_num_sets  in  ADDR_WIDTH  number of sets to deliver, latched on accepted start
- i_consume  in  1  consumer has finished with current set; meaningful only while o_valid
- i_abort  in  1  synchronous abort
- o_mem_en  out  1  memory read enable
- o_mem_addr  out  ADDR_WIDTH  shared read address
- i_mem_data  in  NUM_MAC*KERNEL_WIDTH  read data, MAC m at slice m; valid RD_LAT edges after the issuing edge
- o_kernel  out  NUM_MAC*TAPS*KERNEL_WIDTH  active set, word (m,t) at slice m*TAPS+t
- o_valid  out  1  o_kernel holds a complete, unconsumed set
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse after the last set is consumed

## Operation
- States: IDLE, FETCH, FULL, DRAIN.
- IDLE → FETCH on i_start. Latch base and count, and set addr ← base. With i_num_sets = 0: no fetch, o_done pulses the next cycle, stay IDLE.
- FETCH: issue TAPS reads at addr, addr+1, …, one per cycle, o_mem_en high. addr keeps advancing across sets, so set s word t comes from base + s*TAPS + t, wrapping mod 2^ADDR_WIDTH.
- An RD_LAT-deep enable-delay pipe marks returning data. Each captured word shifts into the shadow bank per MAC: tap TAPS-1 ← data, tap t ← tap t+1. The first word of a set ends in tap 0.
- After the TAPS-th capture, go to FULL.
- FULL: transfer shadow → active when !o_valid or i_consume. On transfer, o_valid ← 1 and sets_fetched++. Then go to FETCH if sets_fetched < num_sets, else DRAIN. Prefetch therefore overlaps consumption.
- i_consume with o_valid and no transfer that edge: o_valid ← 0.
- DRAIN: on o_valid && i_consume, o_valid ← 0, o_done ← 1 for one cycle, then IDLE.
- i_abort, any state: next edge goes to IDLE with o_valid = 0, active and shadow banks zeroed, delay pipe flushed, o_mem_en = 0, no o_done. Abort wins over a simultaneous start, consume or transfer.
- i_start outside IDLE is ignored. i_consume while !o_valid is ignored.
- o_kernel holds its last value after final consume until the next transfer, abort or reset. Consumers qualify it with o_valid.

## Timing
- Reset (rstn low, asynchronous): state IDLE, o_mem_en = 0, o_mem_addr = 0, o_kernel = 0, o_valid = 0, o_busy = 0, o_done = 0, all counters and pipes 0.
- Edge 0 is the edge that samples i_start. Reads issue at edges 1..TAPS, with o_mem_en/o_mem_addr registered after edge 0..TAPS-1. Word j is captured at edge j+RD_LAT.
- FULL is entered after edge TAPS+RD_LAT. First transfer is at edge TAPS+RD_LAT+1, and o_valid is high after it.
- A consume coinciding with a FULL transfer gives a seamless swap: o_valid stays 1 and o_kernel changes that edge.
- Steady-state set period is TAPS+RD_LAT+1 cycles when the consumer is faster than the fetch.
- o_done is high exactly one cycle, the cycle after the final consume edge. o_busy falls the same edge.

## Test plan
- Memory model returns {m, addr} per MAC; NUM_MAC=4, TAPS=3, RD_LAT=1. Start base=0x010, num_sets=1 -> reads 0x010..0x012. o_valid rises after edge 5 with tap t of MAC m = {m, 0x010+t}. Consume -> o_done one cycle later.
- num_sets=4 with i_consume tied high -> four sets at addresses 0x010+3s, each held ≥1 cycle, no set skipped. o_done follows the 4th consume.
- num_sets=3 with consume withheld 20 cycles -> FULL holds, o_mem_en low, set 0 stable. Consume -> set 1 appears on the same edge, o_valid stays 1.
- base=0x3FE, num_sets=2 -> addresses 0x3FE, 0x3FF, 0x000, 0x001, 0x002, 0x003.
- Abort during second set's fetch, then start base=0x100 -> no o_done, kernels zero. New run delivers only {m, 0x100+t} data, with no stale captures.
- num_sets=0 -> no o_mem_en, o_done one cycle after start. rstn pulsed mid-fetch -> all outputs 0 immediately.
